// File: rtl/route_table_engine.sv
// Serialized route computation: one head flit at a time, chosen round-robin, matched against
// a runtime-writable route LUT walked one entry per cycle. Allocations hold until route_done.
module route_table_engine #(
    parameter int unsigned NODE           = 1,
    parameter int unsigned NUM_BUFFERS    = 4,
    parameter int unsigned NUM_OUTPORTS   = 4,
    parameter int unsigned LUT_ENTRIES    = 16,
    parameter int unsigned NODE_W         = 5,
    parameter logic [3:0]  FMT_SWITCH_CFG = 4'd3,
    localparam int unsigned SEL_W = $clog2(NUM_OUTPORTS) + ((NUM_OUTPORTS == 1) ? 1 : 0),
    localparam int unsigned AW    = $clog2(LUT_ENTRIES)
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic [NUM_BUFFERS-1:0]              head_valid,
    input  logic [NUM_BUFFERS-1:0][NODE_W-1:0]  head_req,
    input  logic [NUM_BUFFERS-1:0][NODE_W-1:0]  head_dest,
    input  logic [NUM_BUFFERS-1:0][3:0]         head_fmt,
    input  logic [NUM_BUFFERS-1:0]              route_done,
    input  logic                                lut_we,
    input  logic [AW-1:0]                       lut_addr,
    input  logic                                lut_wvalid,
    input  logic [NODE_W-1:0]                   lut_wreq,
    input  logic [NODE_W-1:0]                   lut_wdest,
    input  logic [SEL_W-1:0]                    lut_wsel,
    output logic [NUM_BUFFERS-1:0]              allocate,
    output logic [NUM_BUFFERS-1:0][SEL_W-1:0]   out_sel,
    output logic [NUM_BUFFERS-1:0]              cfg_consume,
    output logic [NUM_BUFFERS-1:0]              route_miss,
    output logic                                busy
);

    localparam int unsigned BW = $clog2(NUM_BUFFERS) + ((NUM_BUFFERS == 1) ? 1 : 0);
    localparam logic [NODE_W-1:0] NODE_ID  = NODE_W'(NODE);
    localparam logic [AW-1:0]     LUT_LAST = AW'(LUT_ENTRIES - 1);
    localparam logic [BW-1:0]     BUF_LAST = BW'(NUM_BUFFERS - 1);

    typedef enum logic {StIdle, StSearch} state_t;

    state_t                                state_q;
    logic [BW-1:0]                         idx_q;
    logic [BW-1:0]                         rr_ptr_q;
    logic [NODE_W-1:0]                     req_q;
    logic [NODE_W-1:0]                     dest_q;
    logic [3:0]                            fmt_q;
    logic [AW-1:0]                         lut_ptr_q;
    logic [NUM_BUFFERS-1:0]                miss_hold_q;
    logic [LUT_ENTRIES-1:0]                lut_valid_q;
    logic [LUT_ENTRIES-1:0][NODE_W-1:0]    lut_req_q;
    logic [LUT_ENTRIES-1:0][NODE_W-1:0]    lut_dest_q;
    logic [LUT_ENTRIES-1:0][SEL_W-1:0]     lut_sel_q;

    logic [NUM_BUFFERS-1:0] eligible;
    logic                   pick_found;
    logic [BW-1:0]          pick_idx;
    logic [BW-1:0]          cand_idx;
    int unsigned            cand;
    logic [BW-1:0]          next_rr;
    logic                   is_local;
    logic                   is_cfg;
    logic                   lut_hit;

    assign eligible = head_valid & ~allocate & ~miss_hold_q;
    assign busy     = (state_q == StSearch);
    assign is_local = (dest_q == NODE_ID);
    assign is_cfg   = is_local && (fmt_q == FMT_SWITCH_CFG);
    assign lut_hit  = lut_valid_q[lut_ptr_q] && (lut_req_q[lut_ptr_q] == req_q)
                      && (lut_dest_q[lut_ptr_q] == dest_q);
    assign next_rr  = (idx_q == BUF_LAST) ? '0 : idx_q + BW'(1);

    // First eligible buffer scanning upward (with wrap) from rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NUM_BUFFERS;
            cand_idx = BW'(cand);
            if (!pick_found && eligible[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            req_q       <= '0;
            dest_q      <= '0;
            fmt_q       <= '0;
            lut_ptr_q   <= '0;
            miss_hold_q <= '0;
            lut_valid_q <= '0;
            lut_req_q   <= '0;
            lut_dest_q  <= '0;
            lut_sel_q   <= '0;
            allocate    <= '0;
            out_sel     <= '0;
            cfg_consume <= '0;
            route_miss  <= '0;
        end else begin
            cfg_consume <= '0;
            route_miss  <= '0;
            allocate    <= allocate & ~route_done;
            miss_hold_q <= miss_hold_q & head_valid;

            if (lut_we) begin
                lut_valid_q[lut_addr] <= lut_wvalid;
                lut_req_q[lut_addr]   <= lut_wreq;
                lut_dest_q[lut_addr]  <= lut_wdest;
                lut_sel_q[lut_addr]   <= lut_wsel;
            end

            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        idx_q     <= pick_idx;
                        req_q     <= head_req[pick_idx];
                        dest_q    <= head_dest[pick_idx];
                        fmt_q     <= head_fmt[pick_idx];
                        lut_ptr_q <= '0;
                        state_q   <= StSearch;
                    end
                end
                StSearch: begin
                    // Rules are strictly prioritised; a dropped head abandons without side effects.
                    if (!head_valid[idx_q]) begin
                        state_q <= StIdle;
                    end else if (is_cfg) begin
                        cfg_consume[idx_q] <= 1'b1;
                        rr_ptr_q           <= next_rr;
                        state_q            <= StIdle;
                    end else if (is_local) begin
                        out_sel[idx_q]  <= '0;
                        allocate[idx_q] <= 1'b1;
                        rr_ptr_q        <= next_rr;
                        state_q         <= StIdle;
                    end else if (lut_hit) begin
                        out_sel[idx_q]  <= lut_sel_q[lut_ptr_q];
                        allocate[idx_q] <= 1'b1;
                        rr_ptr_q        <= next_rr;
                        state_q         <= StIdle;
                    end else if (lut_ptr_q == LUT_LAST) begin
                        route_miss[idx_q]  <= 1'b1;
                        miss_hold_q[idx_q] <= 1'b1;
                        rr_ptr_q           <= next_rr;
                        state_q            <= StIdle;
                    end else begin
                        lut_ptr_q <= lut_ptr_q + AW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_route_table_engine.sv
// Self-checking bench for route_table_engine: directed vector table, hand-written corner
// sequences, then randomized traffic against a latency-level reference model.
module tb_route_table_engine;

    localparam int NB   = 4;
    localparam int LE   = 16;
    localparam int NW   = 5;
    localparam int SW   = 2;
    localparam int AW   = 4;
    localparam int NODE = 1;
    localparam logic [3:0] CFG = 4'd3;

    logic clk = 1'b0;
    logic n_rst;
    logic [NB-1:0]         head_valid;
    logic [NB-1:0][NW-1:0] head_req;
    logic [NB-1:0][NW-1:0] head_dest;
    logic [NB-1:0][3:0]    head_fmt;
    logic [NB-1:0]         route_done;
    logic                  lut_we;
    logic [AW-1:0]         lut_addr;
    logic                  lut_wvalid;
    logic [NW-1:0]         lut_wreq;
    logic [NW-1:0]         lut_wdest;
    logic [SW-1:0]         lut_wsel;
    logic [NB-1:0]         allocate;
    logic [NB-1:0][SW-1:0] out_sel;
    logic [NB-1:0]         cfg_consume;
    logic [NB-1:0]         route_miss;
    logic                  busy;

    route_table_engine #(
        .NODE           (NODE),
        .NUM_BUFFERS    (NB),
        .NUM_OUTPORTS   (4),
        .LUT_ENTRIES    (LE),
        .NODE_W         (NW),
        .FMT_SWITCH_CFG (CFG)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .head_valid  (head_valid),
        .head_req    (head_req),
        .head_dest   (head_dest),
        .head_fmt    (head_fmt),
        .route_done  (route_done),
        .lut_we      (lut_we),
        .lut_addr    (lut_addr),
        .lut_wvalid  (lut_wvalid),
        .lut_wreq    (lut_wreq),
        .lut_wdest   (lut_wdest),
        .lut_wsel    (lut_wsel),
        .allocate    (allocate),
        .out_sel     (out_sel),
        .cfg_consume (cfg_consume),
        .route_miss  (route_miss),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference copy of the route table.
    logic          ml_valid [LE];
    logic [NW-1:0] ml_req   [LE];
    logic [NW-1:0] ml_dest  [LE];
    logic [SW-1:0] ml_sel   [LE];

    task automatic lut_write(input int a, input logic v, input int rq, input int ds, input int sl);
        lut_we     = 1'b1;
        lut_addr   = AW'(a);
        lut_wvalid = v;
        lut_wreq   = NW'(rq);
        lut_wdest  = NW'(ds);
        lut_wsel   = SW'(sl);
        ml_valid[a] = v;
        ml_req[a]   = NW'(rq);
        ml_dest[a]  = NW'(ds);
        ml_sel[a]   = SW'(sl);
        tick();
        lut_we = 1'b0;
    endtask

    task automatic do_reset();
        head_valid = '0;
        route_done = '0;
        lut_we     = 1'b0;
        n_rst      = 1'b0;
        #2;
        n_rst      = 1'b1;
        for (int i = 0; i < LE; i++) ml_valid[i] = 1'b0;
        tick();
    endtask

    // Outcome kind: 0 = allocated, 1 = cfg consumed, 2 = miss. Latency counted from the pick edge.
    function automatic void route_of(input logic [NW-1:0] req, input logic [NW-1:0] dest,
                                     input logic [3:0] fmt, output int kind,
                                     output logic [SW-1:0] sel, output int lat);
        kind = 2;
        sel  = '0;
        lat  = LE;
        if (dest == NW'(NODE)) begin
            lat  = 1;
            kind = (fmt == CFG) ? 1 : 0;
        end else begin
            for (int m = LE - 1; m >= 0; m--) begin
                if (ml_valid[m] && ml_req[m] == req && ml_dest[m] == dest) begin
                    kind = 0;
                    sel  = ml_sel[m];
                    lat  = 1 + m;
                end
            end
        end
    endfunction

    // Reference model state
    logic [NB-1:0]         m_alloc, m_hold, m_cfg, m_miss;
    logic [NB-1:0][SW-1:0] m_sel;
    logic                  m_busy;
    int                    m_idx, m_rr, m_edge, m_done_edge, m_kind;
    logic [SW-1:0]         m_rsel;

    task automatic model_step();
        logic [NB-1:0] old_alloc;
        logic [NB-1:0] old_hold;
        int lat;
        old_alloc = m_alloc;
        old_hold  = m_hold;
        m_edge++;
        m_cfg   = '0;
        m_miss  = '0;
        m_alloc = m_alloc & ~route_done;
        m_hold  = m_hold & head_valid;
        if (m_busy) begin
            if (m_edge == m_done_edge) begin
                case (m_kind)
                    0: begin
                        m_alloc[m_idx] = 1'b1;
                        m_sel[m_idx]   = m_rsel;
                    end
                    1: m_cfg[m_idx] = 1'b1;
                    default: begin
                        m_miss[m_idx] = 1'b1;
                        m_hold[m_idx] = 1'b1;
                    end
                endcase
                m_busy = 1'b0;
                m_rr   = (m_idx + 1) % NB;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                int c;
                c = (m_rr + i) % NB;
                if (!m_busy && head_valid[c] && !old_alloc[c] && !old_hold[c]) begin
                    m_busy = 1'b1;
                    m_idx  = c;
                    route_of(head_req[c], head_dest[c], head_fmt[c], m_kind, m_rsel, lat);
                    m_done_edge = m_edge + lat;
                end
            end
        end
    endtask

    typedef struct {
        int         bk;
        int         req;
        int         dest;
        logic [3:0] fmt;
        int         kind;
        int         sel;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        int   meas;
        logic busy_all;
        logic seen;
        meas     = -1;
        busy_all = 1'b1;
        head_req[v.bk]   = NW'(v.req);
        head_dest[v.bk]  = NW'(v.dest);
        head_fmt[v.bk]   = v.fmt;
        head_valid[v.bk] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (allocate[v.bk] || cfg_consume[v.bk] || route_miss[v.bk]) begin
                meas = n;
                break;
            end
            busy_all &= busy;
        end
        check("vec latency", 32'(meas), 32'(v.lat));
        check("vec busy during search", 32'(busy_all), 32'd1);
        check("vec busy after result", 32'(busy), 32'd0);
        check("vec allocate", 32'(allocate[v.bk]), 32'(v.kind == 0));
        check("vec cfg_consume", 32'(cfg_consume[v.bk]), 32'(v.kind == 1));
        check("vec route_miss", 32'(route_miss[v.bk]), 32'(v.kind == 2));
        if (v.kind == 0) begin
            check("vec out_sel", 32'(out_sel[v.bk]), 32'(v.sel));
            route_done[v.bk] = 1'b1;
            head_valid[v.bk] = 1'b0;
            tick();
            route_done = '0;
            check("vec release allocate", 32'(allocate[v.bk]), 32'd0);
            check("vec out_sel kept", 32'(out_sel[v.bk]), 32'(v.sel));
        end else if (v.kind == 1) begin
            head_valid[v.bk] = 1'b0;
            tick();
            check("vec cfg one cycle", 32'(cfg_consume[v.bk]), 32'd0);
            check("vec cfg no allocate", 32'(allocate[v.bk]), 32'd0);
        end else begin
            seen = 1'b0;
            repeat (5) begin
                tick();
                seen |= route_miss[v.bk] | busy;
            end
            check("vec miss no retry", 32'(seen), 32'd0);
            head_valid[v.bk] = 1'b0;
            tick();
            head_valid[v.bk] = 1'b1;
            tick();
            check("vec miss retry on re-present", 32'(busy), 32'd1);
            head_valid[v.bk] = 1'b0;
            tick();
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   meas;
        logic seen;
        n_rst      = 1'b0;
        head_valid = '0;
        head_req   = '0;
        head_dest  = '0;
        head_fmt   = '0;
        route_done = '0;
        lut_we     = 1'b0;
        lut_addr   = '0;
        lut_wvalid = 1'b0;
        lut_wreq   = '0;
        lut_wdest  = '0;
        lut_wsel   = '0;
        for (int i = 0; i < LE; i++) ml_valid[i] = 1'b0;

        // Reset state
        #2;
        check("reset allocate", 32'(allocate), 32'd0);
        check("reset out_sel", 32'(out_sel), 32'd0);
        check("reset cfg_consume", 32'(cfg_consume), 32'd0);
        check("reset route_miss", 32'(route_miss), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        #10;
        n_rst = 1'b1;
        tick();
        check("post-reset busy", 32'(busy), 32'd0);

        // Directed vectors
        lut_write(3, 1'b1, 2, 5, 2);
        lut_write(5, 1'b0, 4, 7, 1);
        lut_write(7, 1'b1, 3, 6, 1);
        lut_write(9, 1'b1, 2, 5, 3);
        lut_write(15, 1'b1, 0, 9, 3);
        vecs[0] = '{0, 2, 5, 4'd0, 0, 2, 4};
        vecs[1] = '{2, 0, 1, 4'd0, 0, 0, 1};
        vecs[2] = '{1, 0, 1, CFG, 1, 0, 1};
        vecs[3] = '{3, 3, 6, 4'd0, 0, 1, 8};
        vecs[4] = '{0, 0, 9, 4'd0, 0, 3, 16};
        vecs[5] = '{1, 4, 7, 4'd0, 2, 0, 16};
        vecs[6] = '{2, 2, 5, CFG, 0, 2, 4};
        vecs[7] = '{3, 5, 1, 4'd1, 0, 0, 1};
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // LUT writes during a search: entry 1 written as it is compared (old value used),
        // entry 10 written ahead of the pointer (found).
        head_req[2]   = NW'(6);
        head_dest[2]  = NW'(6);
        head_fmt[2]   = 4'd0;
        head_valid[2] = 1'b1;
        meas = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            lut_we = 1'b0;
            if (allocate[2] || route_miss[2]) begin
                meas = n;
                break;
            end
            if (n == 1) begin
                lut_we = 1'b1; lut_addr = AW'(1); lut_wvalid = 1'b1;
                lut_wreq = NW'(6); lut_wdest = NW'(6); lut_wsel = SW'(0);
            end
            if (n == 2) begin
                lut_we = 1'b1; lut_addr = AW'(10); lut_wvalid = 1'b1;
                lut_wreq = NW'(6); lut_wdest = NW'(6); lut_wsel = SW'(1);
            end
        end
        lut_we = 1'b0;
        check("midwrite latency", 32'(meas), 32'd11);
        check("midwrite out_sel", 32'(out_sel[2]), 32'd1);
        route_done[2] = 1'b1;
        head_valid[2] = 1'b0;
        tick();
        route_done = '0;

        // Reset mid-search: nothing committed, LUT invalidated.
        head_req[0]   = NW'(2);
        head_dest[0]  = NW'(5);
        head_fmt[0]   = 4'd0;
        head_valid[0] = 1'b1;
        repeat (3) tick();
        n_rst = 1'b0;
        #1;
        check("midreset allocate", 32'(allocate), 32'd0);
        check("midreset out_sel", 32'(out_sel), 32'd0);
        check("midreset pulses", 32'({cfg_consume, route_miss}), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        #1;
        n_rst = 1'b1;
        meas = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (allocate[0] || route_miss[0]) begin
                meas = n;
                break;
            end
        end
        check("post-reset LUT empty latency", 32'(meas), 32'd16);
        check("post-reset LUT empty miss", 32'(route_miss[0]), 32'd1);
        head_valid[0] = 1'b0;
        tick();

        // Round-robin: heads 0,1,3 local; 0 released and re-presented right after its grant.
        do_reset();
        for (int k = 0; k < NB; k++) begin
            head_req[k]  = NW'(0);
            head_dest[k] = NW'(1);
            head_fmt[k]  = 4'd0;
        end
        head_valid = 4'b1011;
        tick();
        check("rr E busy", 32'(busy), 32'd1);
        tick();
        check("rr E+1 alloc", 32'(allocate), 32'b0001);
        route_done = 4'b0001;
        tick();
        route_done = '0;
        check("rr E+2 alloc", 32'(allocate), 32'b0000);
        tick();
        check("rr E+3 alloc", 32'(allocate), 32'b0010);
        tick();
        tick();
        check("rr E+5 alloc", 32'(allocate), 32'b1010);
        tick();
        tick();
        check("rr E+7 alloc", 32'(allocate), 32'b1011);
        route_done = 4'b1011;
        head_valid = '0;
        tick();
        route_done = '0;
        check("rr release", 32'(allocate), 32'd0);

        // Abort: head 0 dropped while lut_ptr = 5.
        head_req[0]   = NW'(7);
        head_dest[0]  = NW'(7);
        head_valid[0] = 1'b1;
        repeat (6) tick();
        head_valid[0] = 1'b0;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort allocate", 32'(allocate[0]), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= route_miss[0] | allocate[0] | busy;
        end
        check("abort no late result", 32'(seen), 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int a = 0; a < LE; a++) begin
            int d;
            d = $urandom_range(7);
            if (d == NODE) d = 0;
            lut_write(a, ($urandom_range(3) != 0), $urandom_range(3), d, $urandom_range(3));
        end
        m_alloc = '0; m_hold = '0; m_cfg = '0; m_miss = '0; m_sel = '0;
        m_busy  = 1'b0; m_rr = 0; m_edge = 0; m_done_edge = 0; m_idx = 0; m_kind = 0;
        m_rsel  = '0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(posedge clk);
            model_step();
            #1;
            check("rnd allocate", 32'(allocate), 32'(m_alloc));
            check("rnd out_sel", 32'(out_sel), 32'(m_sel));
            check("rnd cfg_consume", 32'(cfg_consume), 32'(m_cfg));
            check("rnd route_miss", 32'(route_miss), 32'(m_miss));
            check("rnd busy", 32'(busy), 32'(m_busy));
            route_done = '0;
            for (int k = 0; k < NB; k++) begin
                if (m_alloc[k]) begin
                    if ($urandom_range(3) == 0) begin
                        route_done[k] = 1'b1;
                        head_valid[k] = 1'b0;
                    end
                end else if (m_cfg[k]) begin
                    head_valid[k] = 1'b0;
                end else if (m_hold[k]) begin
                    if ($urandom_range(2) == 0) head_valid[k] = 1'b0;
                end else if (!head_valid[k]) begin
                    if ($urandom_range(1) == 0) begin
                        head_req[k]   = NW'($urandom_range(3));
                        head_dest[k]  = NW'($urandom_range(7));
                        head_fmt[k]   = ($urandom_range(3) == 0) ? CFG : 4'($urandom_range(2));
                        head_valid[k] = 1'b1;
                    end
                end else if ($urandom_range(7) == 0) begin
                    route_done[k] = 1'b1;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/route_table_engine.md
Name: route_table_engine

Overview:
- Serialized, table-driven route computation for the switch; replaces the all-parallel per-buffer route compute.
- Services one input buffer's head flit at a time, chosen round-robin.
- Walks an internally owned, runtime-writable route LUT one entry per cycle.
- Holds each resulting allocation until the packet tail releases it.
- Sits between the input buffers and the switch allocator.

Parameters:
NODE, 1, node_id_t of this switch; heads destined here route to port 0.
NUM_BUFFERS, 4, input buffers serviced.
NUM_OUTPORTS, 4, output ports; SEL_W = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1).
LUT_ENTRIES, 16, route table depth; AW = $clog2(LUT_ENTRIES).
NODE_W, 5, node id width.

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
head_valid  in  [NUM_BUFFERS]  buffer k presents an unrouted head flit
head_req  in  [NUM_BUFFERS][NODE_W]  source id of head k
head_dest  in  [NUM_BUFFERS][NODE_W]  destination id (payload[27:23])
head_fmt  in  [NUM_BUFFERS][4]  format_e (payload[31:28])
route_done  in  [NUM_BUFFERS]  tail of buffer k has left; release its allocation
lut_we  in  1  LUT write strobe
lut_addr  in  AW  LUT write index
lut_wvalid  in  1  entry valid bit to write
lut_wreq  in  NODE_W  entry req field
lut_wdest  in  NODE_W  entry dest field
lut_wsel  in  SEL_W  entry out_sel field
allocate  out  [NUM_BUFFERS]  buffer k holds a computed route
out_sel  out  [NUM_BUFFERS][SEL_W]  output port for buffer k
cfg_consume  out  [NUM_BUFFERS]  1-cycle pulse: head k is a switch-config flit for this node; buffer discards it
route_miss  out  [NUM_BUFFERS]  1-cycle pulse: no LUT match for head k
busy  out  1  FSM not IDLE

Behaviour:
- Reset: allocate, out_sel, cfg_consume, route_miss, miss_hold = 0; every LUT valid bit = 0; rr_ptr = 0; FSM = IDLE. Reset mid-search abandons the search; nothing is committed.
- Eligible(k) = head_valid[k] & !allocate[k] & !miss_hold[k].
- IDLE:
  - Pick the first eligible k scanning rr_ptr, rr_ptr+1, … (mod NUM_BUFFERS).
  - Latch idx, req, dest, fmt; clear lut_ptr; go to SEARCH.
  - With no eligible buffer, stay in IDLE.
- SEARCH (per cycle, first applicable rule wins):
  1. head_valid[idx] = 0: abort to IDLE, no output change, rr_ptr unchanged.
  2. fmt == FMT_SWITCH_CFG and dest == NODE: pulse cfg_consume[idx]; allocate[idx] stays 0; go to IDLE.
  3. dest == NODE: out_sel[idx] = 0, allocate[idx] = 1; go to IDLE.
  4. LUT[lut_ptr] valid with req and dest both equal: out_sel[idx] = LUT.sel, allocate[idx] = 1; go to IDLE. Lowest matching index wins.
  5. lut_ptr == LUT_ENTRIES-1: pulse route_miss[idx], set miss_hold[idx]; go to IDLE.
  6. Otherwise: lut_ptr++.
- rr_ptr = idx+1 (mod NUM_BUFFERS) on every exit via rules 2–5.
- Latency: head_valid sampled at edge E. Local or cfg result is visible after edge E+1. A LUT match at index m is visible after edge E+1+m. A miss is visible after edge E+LUT_ENTRIES.
- allocate[k] and out_sel[k] hold until route_done[k]; the next edge then clears allocate[k], and out_sel[k] keeps its last value. A buffer released by route_done is eligible from the following cycle.
- miss_hold[k] clears when head_valid[k] = 0. The missing head is not retried until the buffer re-presents it.
- LUT write: takes effect at the edge. A comparison in the same cycle uses the old entry. A search in progress continues; an entry already passed is not revisited.
- route_done[k] asserted while k is unallocated has no effect.

Test Plan:
- NODE=1; LUT[3] = {valid, req 2, dest 5, sel 2}; head 0 = req 2, dest 5, normal format -> allocate[0]=1, out_sel[0]=2 after edge E+4; busy high E+1..E+4.
- Head 2 dest 1, normal format -> out_sel[2]=0, allocate[2]=1 after edge E+1; route_done[2] -> allocate[2]=0 next edge.
- Head 1 dest 1, FMT_SWITCH_CFG -> cfg_consume[1] high for exactly one cycle; allocate[1] stays 0.
- Head 0 dest 7, LUT empty -> route_miss[0] pulses once after edge E+16; no retry until head_valid[0] drops and reasserts.
- Heads 0, 1, 3 valid simultaneously, all local -> allocations in order 0, 1, 3, one per two cycles. A new head on 0 after its route_done is serviced after 1 and 3 (round-robin).
- head_valid[0] dropped at lut_ptr=5 -> FSM returns to IDLE, allocate[0]=0. Separately, n_rst low mid-search -> all outputs 0 and LUT invalid.
